// File: rtl/echo_app_tx_msg_if_ctrl.sv
// echo_app_tx_msg_if_ctrl: control FSM that requests TX buffer space, writes payload beats and updates the TX tail pointer
package echo_app_tx_msg_if_ctrl_pkg;
  typedef enum logic {SPACE_REQ = 1'b0, PTR_UPDATE = 1'b1} tx_buf_mux_sel_e;
endpackage

module echo_app_tx_msg_if_ctrl
  import echo_app_tx_msg_if_ctrl_pkg::*;
#(
  parameter int LEN_W          = 16,
  parameter int CHUNK_BYTES    = 64,
  parameter int BACKOFF_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rx_if_tx_if_msg_val,
  output logic             o_tx_if_rx_if_msg_rdy,
  output logic             o_tx_app_noc_vrtoc_val,
  input  logic             i_noc_vrtoc_tx_app_rdy,
  input  logic             i_noc_ctovr_tx_app_val,
  output logic             o_tx_app_noc_ctovr_rdy,
  output logic             o_ctrl_wr_buf_req_val,
  input  logic             i_wr_buf_ctrl_req_rdy,
  output logic             o_ctrl_wr_buf_data_val,
  output logic             o_ctrl_wr_buf_data_last,
  input  logic             i_wr_buf_ctrl_data_rdy,
  output logic             o_ctrl_datap_store_msg,
  output logic             o_ctrl_datap_store_notif,
  output logic             o_ctrl_datap_incr_beat,
  output tx_buf_mux_sel_e  o_ctrl_datap_buf_mux_sel,
  input  logic [LEN_W-1:0] i_datap_ctrl_msg_len,
  input  logic             i_datap_ctrl_space_ok
);
  localparam int LW1 = LEN_W + 1;
  localparam int CW  = $clog2(CHUNK_BYTES);
  localparam int BW  = $clog2(BACKOFF_CYCLES + 1);
  typedef enum logic [2:0] {
    READY, REQ_SPACE, SPACE_NOTIF, CHECK_SPACE, BACKOFF, WR_REQ, WR_DATA, ADJUST_TX_TAIL
  } state_e;
  state_e          r_state, w_next;
  logic [LW1-1:0]  r_beat_cnt, w_total_beats;
  logic [BW-1:0]   r_backoff_cnt;
  logic            w_last, w_backoff_done;
  assign w_total_beats  = (LW1'(i_datap_ctrl_msg_len) + LW1'(CHUNK_BYTES - 1)) >> CW;
  assign w_last         = r_beat_cnt == w_total_beats - 1'b1;
  assign w_backoff_done = r_backoff_cnt == BW'(BACKOFF_CYCLES - 1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= READY;
      r_beat_cnt    <= '0;
      r_backoff_cnt <= '0;
    end else begin
      r_state       <= w_next;
      r_beat_cnt    <= r_state == CHECK_SPACE ? '0 :
                       (r_state == WR_DATA && i_wr_buf_ctrl_data_rdy) ? r_beat_cnt + 1'b1 : r_beat_cnt;
      r_backoff_cnt <= r_state == CHECK_SPACE ? '0 :
                       r_state == BACKOFF ? r_backoff_cnt + 1'b1 : r_backoff_cnt;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      READY:          w_next = (i_rx_if_tx_if_msg_val && i_datap_ctrl_msg_len != '0) ? REQ_SPACE : READY;
      REQ_SPACE:      w_next = i_noc_vrtoc_tx_app_rdy ? SPACE_NOTIF : REQ_SPACE;
      SPACE_NOTIF:    w_next = i_noc_ctovr_tx_app_val ? CHECK_SPACE : SPACE_NOTIF;
      CHECK_SPACE:    w_next = i_datap_ctrl_space_ok ? WR_REQ : BACKOFF;
      BACKOFF:        w_next = w_backoff_done ? REQ_SPACE : BACKOFF;
      WR_REQ:         w_next = i_wr_buf_ctrl_req_rdy ? WR_DATA : WR_REQ;
      WR_DATA:        w_next = (i_wr_buf_ctrl_data_rdy && w_last) ? ADJUST_TX_TAIL : WR_DATA;
      ADJUST_TX_TAIL: w_next = i_noc_vrtoc_tx_app_rdy ? READY : ADJUST_TX_TAIL;
      default:        w_next = state_e'(3'bx);
    endcase
  end
  always_comb begin
    o_tx_if_rx_if_msg_rdy    = 1'b0;
    o_tx_app_noc_vrtoc_val   = 1'b0;
    o_tx_app_noc_ctovr_rdy   = 1'b0;
    o_ctrl_wr_buf_req_val    = 1'b0;
    o_ctrl_wr_buf_data_val   = 1'b0;
    o_ctrl_wr_buf_data_last  = 1'b0;
    o_ctrl_datap_store_msg   = 1'b0;
    o_ctrl_datap_store_notif = 1'b0;
    o_ctrl_datap_incr_beat   = 1'b0;
    o_ctrl_datap_buf_mux_sel = SPACE_REQ;
    if (i_rst_n)
      case (r_state)
        READY: begin
          o_tx_if_rx_if_msg_rdy  = 1'b1;
          o_ctrl_datap_store_msg = i_rx_if_tx_if_msg_val;
        end
        REQ_SPACE: o_tx_app_noc_vrtoc_val = 1'b1;
        SPACE_NOTIF: begin
          o_tx_app_noc_ctovr_rdy   = 1'b1;
          o_ctrl_datap_store_notif = 1'b1;
        end
        CHECK_SPACE, BACKOFF: ;
        WR_REQ: o_ctrl_wr_buf_req_val = 1'b1;
        WR_DATA: begin
          o_ctrl_wr_buf_data_val  = 1'b1;
          o_ctrl_wr_buf_data_last = w_last;
          o_ctrl_datap_incr_beat  = i_wr_buf_ctrl_data_rdy;
        end
        ADJUST_TX_TAIL: begin
          o_tx_app_noc_vrtoc_val   = 1'b1;
          o_ctrl_datap_buf_mux_sel = PTR_UPDATE;
        end
        default: begin
          o_tx_if_rx_if_msg_rdy    = 1'bx;
          o_tx_app_noc_vrtoc_val   = 1'bx;
          o_tx_app_noc_ctovr_rdy   = 1'bx;
          o_ctrl_wr_buf_req_val    = 1'bx;
          o_ctrl_wr_buf_data_val   = 1'bx;
          o_ctrl_wr_buf_data_last  = 1'bx;
          o_ctrl_datap_store_msg   = 1'bx;
          o_ctrl_datap_store_notif = 1'bx;
          o_ctrl_datap_incr_beat   = 1'bx;
          o_ctrl_datap_buf_mux_sel = tx_buf_mux_sel_e'(1'bx);
        end
      endcase
  end
endmodule
